// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter sharing one async_fifo write port among NREQ producers.
// Rotating priority, bounded burst per grant, honours wfull back-pressure.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                       wclk,
   input  logic                       wrst,
   input  logic [NREQ-1:0]            src_valid,
   input  logic [NREQ*DW-1:0]         src_data,
   output logic [NREQ-1:0]            src_ready,
   output logic                       wreq,
   output logic [DW-1:0]              wdata,
   input  logic                       wfull,
   output logic [$clog2(NREQ)-1:0]    owner,
   output logic                       busy
);

   localparam int OW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, OWN} state_t;

   state_t          state_q;
   logic [OW-1:0]   ptr_q;
   logic [OW-1:0]   owner_q;
   logic [CW-1:0]   cnt_q;

   logic [OW-1:0]   sel_d;
   logic            any_valid;
   int unsigned     scan_idx;
   logic [DW-1:0]   slice [NREQ];
   logic            own_valid;
   logic            beat;
   logic            last_beat;
   logic [OW-1:0]   ptr_next;

   always_comb begin
      for (int unsigned k = 0; k < NREQ; k++) begin
         slice[k] = src_data[k*DW +: DW];
      end
   end

   // First valid requester scanning ptr, ptr+1, ... modulo NREQ.
   always_comb begin
      sel_d     = ptr_q;
      any_valid = 1'b0;
      scan_idx  = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = (32'(ptr_q) + k) % NREQ;
         if (!any_valid && src_valid[scan_idx[OW-1:0]]) begin
            any_valid = 1'b1;
            sel_d     = scan_idx[OW-1:0];
         end
      end
   end

   assign own_valid = src_valid[owner_q];
   assign beat      = (state_q == OWN) && own_valid && !wfull;
   assign last_beat = (cnt_q == CW'(MAX_BURST - 1));
   assign ptr_next  = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_valid) begin
                  owner_q <= sel_d;
                  cnt_q   <= '0;
                  state_q <= OWN;
               end
            end
            OWN: begin
               if (!own_valid || (beat && last_beat)) begin
                  ptr_q   <= ptr_next;
                  state_q <= IDLE;
               end else if (beat) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      src_ready = '0;
      wdata     = '0;
      if (state_q == OWN) begin
         src_ready[owner_q] = !wfull;
         wdata              = slice[owner_q];
      end
   end

   assign wreq  = beat;
   assign busy  = (state_q == OWN);
   assign owner = owner_q;

endmodule
